// File: rtl/alu_pkg.sv
// Shared definitions for alu_exec_unit: ALUOp codes, MIPS funct constants,
// the internal operation enum, the FSM state enum and the op decoder.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIVZ, OP_BAD
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_EXEC, ST_MUL, ST_DIV, ST_DONE
    } state_e;

    // Map ALUOp/Funct onto an internal op; divide-by-zero is resolved by the caller.
    function automatic op_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
        op_e op;
        op = OP_BAD;
        case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_SLT: op = OP_SLT;
            default: begin
                case (funct)
                    FN_ADD:   op = OP_ADD;
                    FN_SUB:   op = OP_SUB;
                    FN_AND:   op = OP_AND;
                    FN_OR:    op = OP_OR;
                    FN_XOR:   op = OP_XOR;
                    FN_NOR:   op = OP_NOR;
                    FN_SLT:   op = OP_SLT;
                    FN_SLL:   op = OP_SLL;
                    FN_SRL:   op = OP_SRL;
                    FN_SRA:   op = OP_SRA;
                    FN_MFHI:  op = OP_MFHI;
                    FN_MFLO:  op = OP_MFLO;
                    FN_MULT:  op = OP_MULT;
                    FN_MULTU: op = OP_MULTU;
                    FN_DIV:   op = OP_DIV;
                    FN_DIVU:  op = OP_DIVU;
                    default:  op = OP_BAD;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one adder.
// Ports: clk, rst_n (sync, active low), start (load operands), is_div,
//        is_signed, a, b; done_c (results valid this cycle), hi_c, lo_c
//        (sign-corrected {HI,LO} product or remainder/quotient).
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic             div_r;
    logic             neg_lo;   // negate product (mul) or quotient (div)
    logic             neg_hi;   // negate remainder (div only)
    logic [WIDTH-1:0] hi_r;     // product high half / partial remainder
    logic [WIDTH-1:0] lo_r;     // multiplier bits / dividend then quotient
    logic [WIDTH-1:0] d_r;      // magnitude of multiplicand / divisor

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_cin;
    logic [WIDTH+1:0] sum;
    logic [2*WIDTH-1:0] prod_fix;

    // Entry fix-up: iterate on magnitudes, remember result signs.
    always_comb begin
        a_abs = (is_signed && a[WIDTH-1]) ? WIDTH'(0) - a : a;
        b_abs = (is_signed && b[WIDTH-1]) ? WIDTH'(0) - b : b;
    end

    // Shared adder: hi+d for multiply, {rem,next bit}-d (via ~d+1) for divide.
    always_comb begin
        add_x   = {1'b0, hi_r};
        add_y   = {1'b0, d_r};
        add_cin = 1'b0;
        if (div_r) begin
            add_x   = {hi_r, lo_r[WIDTH-1]};
            add_y   = ~{1'b0, d_r};
            add_cin = 1'b1;
        end
        sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(add_cin);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            div_r  <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            d_r    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            div_r  <= is_div;
            neg_lo <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= is_signed & a[WIDTH-1];
            hi_r   <= '0;
            lo_r   <= a_abs;
            d_r    <= b_abs;
        end else if (busy) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
                if (div_r) begin
                    // sum[WIDTH+1] is the no-borrow flag: subtract succeeded.
                    hi_r <= sum[WIDTH+1] ? sum[WIDTH-1:0] : {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
                    lo_r <= {lo_r[WIDTH-2:0], sum[WIDTH+1]};
                end else begin
                    if (lo_r[0]) begin
                        hi_r <= sum[WIDTH:1];
                        lo_r <= {sum[0], lo_r[WIDTH-1:1]};
                    end else begin
                        hi_r <= {1'b0, hi_r[WIDTH-1:1]};
                        lo_r <= {hi_r[0], lo_r[WIDTH-1:1]};
                    end
                end
            end
        end
    end

    // Exit fix-up: restore signs on the raw magnitude results.
    always_comb begin
        done_c   = busy && (cnt == LAST);
        prod_fix = neg_lo ? (2*WIDTH)'(0) - {hi_r, lo_r} : {hi_r, lo_r};
        if (div_r) begin
            hi_c = neg_hi ? WIDTH'(0) - hi_r : hi_r;
            lo_c = neg_lo ? WIDTH'(0) - lo_r : lo_r;
        end else begin
            hi_c = prod_fix[2*WIDTH-1:WIDTH];
            lo_c = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: decodes ALUOp/Funct, runs single-cycle ops or iterative
// mul/div, holds HI/LO, and returns the result over a valid/ready handshake.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready, ALUOp, Funct,
//        Shamt_in, A, B (op in); out_valid/out_ready, Result, Zero, Err (out).
// Shifts operate on A by Shamt_in.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [SHW-1:0]   Shamt_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Err
);

    state_e           state, state_nxt;
    op_e              dec_op, op_q;
    logic [WIDTH-1:0] a_q, b_q, hi, lo;
    logic [SHW-1:0]   shamt_q;

    logic             load, finish, md_start, md_done;
    logic             md_is_div, md_signed;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] res_nxt, hi_nxt, lo_nxt;
    logic             err_nxt;

    // Decode, with divide-by-zero diverted to the single-cycle path.
    always_comb begin
        dec_op = decode_op(ALUOp, Funct);
        if ((dec_op == OP_DIV || dec_op == OP_DIVU) && B == '0) begin
            dec_op = OP_DIVZ;
        end
        md_is_div = (dec_op == OP_DIV) || (dec_op == OP_DIVU);
        md_signed = (dec_op == OP_MULT) || (dec_op == OP_DIV);
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .is_div    (md_is_div),
        .is_signed (md_signed),
        .a         (A),
        .b         (B),
        .done_c    (md_done),
        .hi_c      (md_hi),
        .lo_c      (md_lo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, single-cycle ALU and values captured on entry to DONE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        md_start  = 1'b0;
        finish    = 1'b0;
        res_nxt   = '0;
        err_nxt   = 1'b0;
        hi_nxt    = hi;
        lo_nxt    = lo;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    if (dec_op == OP_MULT || dec_op == OP_MULTU) begin
                        md_start  = 1'b1;
                        state_nxt = ST_MUL;
                    end else if (md_is_div) begin
                        md_start  = 1'b1;
                        state_nxt = ST_DIV;
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                finish    = 1'b1;
                state_nxt = ST_DONE;
                case (op_q)
                    OP_ADD:  res_nxt = a_q + b_q;
                    OP_SUB:  res_nxt = a_q - b_q;
                    OP_AND:  res_nxt = a_q & b_q;
                    OP_OR:   res_nxt = a_q | b_q;
                    OP_XOR:  res_nxt = a_q ^ b_q;
                    OP_NOR:  res_nxt = ~(a_q | b_q);
                    OP_SLT:  res_nxt = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                    OP_SLL:  res_nxt = a_q << shamt_q;
                    OP_SRL:  res_nxt = a_q >> shamt_q;
                    OP_SRA:  res_nxt = WIDTH'($signed(a_q) >>> shamt_q);
                    OP_MFHI: res_nxt = hi;
                    OP_MFLO: res_nxt = lo;
                    OP_DIVZ: begin
                        res_nxt = '1;
                        lo_nxt  = '1;
                        hi_nxt  = a_q;
                    end
                    default: err_nxt = 1'b1;
                endcase
            end
            ST_MUL, ST_DIV: begin
                if (md_done) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                    hi_nxt    = md_hi;
                    lo_nxt    = md_lo;
                    res_nxt   = md_lo;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, HI/LO and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            shamt_q   <= '0;
            hi        <= '0;
            lo        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_DONE);
            if (load) begin
                op_q    <= dec_op;
                a_q     <= A;
                b_q     <= B;
                shamt_q <= Shamt_in;
            end
            if (finish) begin
                hi     <= hi_nxt;
                lo     <= lo_nxt;
                Result <= res_nxt;
                Zero   <= (res_nxt == '0);
                Err    <= err_nxt;
            end
            // Zero/Err are only meaningful alongside out_valid.
            if (state == ST_DONE && out_ready) begin
                Zero <= 1'b0;
                Err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH = 32).
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;
    logic [4:0]  Shamt_in;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        Err;

    int tests  = 0;
    int failed = 0;
    int lat;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct     (Funct),
        .Shamt_in  (Shamt_in),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Err       (Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; presents one op for one edge, then waits
    // (bounded) for out_valid and returns the accept->valid latency.
    task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b, output int l);
        ALUOp = op; Funct = fn; Shamt_in = sh; A = a; B = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 0;
        while (!out_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUOp = 2'b00; Funct = 6'b0; Shamt_in = 5'd0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    Result,         32'd0);
        check("rst_zero",      32'(Zero),      32'd0);

        // add
        run_op(2'b10, 6'b100000, 5'd0, 32'd5, 32'd7, lat);
        check("add_lat",    32'(lat),  32'd1);
        check("add_result", Result,    32'd12);
        check("add_zero",   32'(Zero), 32'd0);
        ack();

        // sra shifts A
        run_op(2'b10, 6'b000011, 5'd4, 32'h8000_0000, 32'd0, lat);
        check("sra_result", Result, 32'hF800_0000);
        ack();

        // sub via ALUOp giving zero, and wrap
        run_op(2'b01, 6'b000000, 5'd0, 32'd5, 32'd5, lat);
        check("sub_zero_res", Result,    32'd0);
        check("sub_zero_flg", 32'(Zero), 32'd1);
        ack();
        run_op(2'b01, 6'b000000, 5'd0, 32'd0, 32'd1, lat);
        check("sub_wrap", Result, 32'hFFFF_FFFF);
        ack();

        // slt via ALUOp and funct, nor, sll
        run_op(2'b11, 6'b000000, 5'd0, 32'hFFFF_FFFF, 32'd1, lat);
        check("slt_aluop", Result, 32'd1);
        ack();
        run_op(2'b10, 6'b101010, 5'd0, 32'd1, 32'hFFFF_FFFF, lat);
        check("slt_funct", Result, 32'd0);
        ack();
        run_op(2'b10, 6'b100111, 5'd0, 32'h0F0F_0000, 32'h0000_00F0, lat);
        check("nor_result", Result, 32'hF0F0_FF0F);
        ack();
        run_op(2'b10, 6'b000000, 5'd8, 32'h0000_00AB, 32'd0, lat);
        check("sll_result", Result, 32'h0000_AB00);
        ack();

        // signed mult -3 * 7
        run_op(2'b10, 6'b011000, 5'd0, 32'hFFFF_FFFD, 32'd7, lat);
        check("mult_lat", 32'(lat), 32'd33);
        check("mult_lo",  Result,   32'hFFFF_FFEB);
        ack();
        run_op(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, lat);
        check("mult_mfhi", Result, 32'hFFFF_FFFF);
        ack();
        run_op(2'b10, 6'b010010, 5'd0, 32'd0, 32'd0, lat);
        check("mult_mflo", Result, 32'hFFFF_FFEB);
        ack();

        // multu large operands: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        run_op(2'b10, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'd2, lat);
        check("multu_lo", Result, 32'hFFFF_FFFE);
        ack();
        run_op(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, lat);
        check("multu_hi", Result, 32'd1);
        ack();

        // signed div -7 / 2
        run_op(2'b10, 6'b011010, 5'd0, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lat", 32'(lat), 32'd33);
        check("div_lo",  Result,   32'hFFFF_FFFD);
        ack();
        run_op(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, lat);
        check("div_hi", Result, 32'hFFFF_FFFF);
        ack();

        // divu 100 / 7 = 14 r 2
        run_op(2'b10, 6'b011011, 5'd0, 32'd100, 32'd7, lat);
        check("divu_lo", Result, 32'd14);
        ack();
        run_op(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, lat);
        check("divu_hi", Result, 32'd2);
        ack();

        // divu by zero
        run_op(2'b10, 6'b011011, 5'd0, 32'd7, 32'd0, lat);
        check("divz_lat", 32'(lat), 32'd1);
        check("divz_lo",  Result,   32'hFFFF_FFFF);
        check("divz_err", 32'(Err), 32'd0);
        ack();
        run_op(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, lat);
        check("divz_hi", Result, 32'd7);
        ack();

        // backpressure: hold out_ready low, intruding op must be ignored
        run_op(2'b10, 6'b100000, 5'd0, 32'd5, 32'd7, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ALUOp = 2'b01; A = 32'd100; B = 32'd1; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_result", Result,         32'd12);
            check("bp_valid",  32'(out_valid), 32'd1);
            check("bp_ready",  32'(in_ready),  32'd0);
        end
        // handshake edge with a new op present: not accepted that edge
        ALUOp = 2'b01; A = 32'd100; B = 32'd1; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_valid", 32'(out_valid), 32'd0);
        check("hs_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hs_accepted", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("hs_result", Result, 32'd99);
        ack();

        // reset in the middle of a mult
        ALUOp = 2'b10; Funct = 6'b011000; A = 32'd9; B = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready),  32'd1);
        run_op(2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, lat);
        check("abort_hi", Result, 32'd0);
        ack();
        run_op(2'b10, 6'b010010, 5'd0, 32'd0, 32'd0, lat);
        check("abort_lo", Result, 32'd0);
        ack();

        // unsupported funct
        run_op(2'b10, 6'b111111, 5'd0, 32'd3, 32'd4, lat);
        check("bad_lat",    32'(lat), 32'd1);
        check("bad_err",    32'(Err), 32'd1);
        check("bad_result", Result,   32'd0);
        ack();
        check("bad_err_clr", 32'(Err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
